free_list_ckpt_ctrl: RTL and testbench

- Owns the branch-checkpoint table for the physical-register free list.
- Captures the free list's checkpoint snapshot when dispatch makes a checkpoint, and returns a tag for it.
- Keeps every live snapshot current with registers freed later by the active list.
- On a mispredict, sequences a one-cycle recall of the matching snapshot and squashes all younger checkpoints.

---
 rtl/free_list_ckpt_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_free_list_ckpt_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_ckpt_ctrl.sv
// free_list_ckpt_ctrl: branch-checkpoint table for the physical-register
// free list. Captures snapshots on ckpt_req and returns a tag (ckpt_tag).
// Patches live snapshots with freed registers (if_freed/freed_reg).
// Retires in order on correct resolves. On a mispredict it squashes
// younger slots and replays the snapshot as a one-cycle recall pulse
// (if_recall, recalled_*, recall_busy). ckpt_full stalls dispatch.
// Define CKPT_PERF_EN to add the perf_mispredicts/perf_full_stalls counters.
module free_list_ckpt_ctrl #(
  parameter int NUM_CKPT = 4,
  parameter int TAG_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ckpt_req,
  input  logic [383:0]     ckpt_list,
  input  logic [5:0]       ckpt_front_ptr,
  input  logic [5:0]       ckpt_back_ptr,
  input  logic [6:0]       ckpt_list_size,
  output logic [TAG_W-1:0] ckpt_tag,
  output logic             ckpt_full,
  input  logic             if_freed,
  input  logic [5:0]       freed_reg,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispredict,
  output logic             if_recall,
  output logic [383:0]     recalled_list,
  output logic [5:0]       recalled_front_ptr,
  output logic [5:0]       recalled_back_ptr,
  output logic [6:0]       recalled_list_size,
  output logic             recall_busy
`ifdef CKPT_PERF_EN
  ,
  output logic [31:0]      perf_mispredicts,
  output logic [31:0]      perf_full_stalls
`endif
);

  typedef enum logic {IDLE, RECALL} state_t;

  state_t state, state_nx;

  logic [TAG_W-1:0]    head, tail, head_nx, tail_nx;
  logic [NUM_CKPT-1:0] valid, done, valid_nx, done_nx;
  logic [NUM_CKPT-1:0] squash;
  logic [TAG_W:0]      count;

  logic [383:0] s_list  [NUM_CKPT];
  logic [5:0]   s_front [NUM_CKPT];
  logic [5:0]   s_back  [NUM_CKPT];
  logic [6:0]   s_size  [NUM_CKPT];

  logic [383:0] p_list  [NUM_CKPT];
  logic [5:0]   p_back  [NUM_CKPT];
  logic [6:0]   p_size  [NUM_CKPT];

  logic [383:0] r_list;
  logic [5:0]   r_front, r_back;
  logic [6:0]   r_size;

  logic alloc, mispred, resolve_ok, retire, rv_mis;

  function automatic logic [383:0] put6(
    input logic [383:0] l,
    input logic [5:0]   idx,
    input logic [5:0]   v
  );
    logic [383:0] o;
    o = l;
    o[int'(idx)*6 +: 6] = v;
    return o;
  endfunction

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CKPT; i++)
      count = count + (TAG_W+1)'(valid[i]);
  end

  assign ckpt_full = (count == (TAG_W+1)'(NUM_CKPT));
  assign ckpt_tag  = tail;

  assign rv_mis     = resolve_valid && resolve_mispredict;
  assign alloc      = ckpt_req && !ckpt_full &&
                      (state == IDLE) && !rv_mis;
  assign mispred    = rv_mis && valid[resolve_tag] &&
                      (state == IDLE);
  assign resolve_ok = resolve_valid && !resolve_mispredict &&
                      valid[resolve_tag];
  // a head that is itself being flushed must not also retire,
  // or head would pass the rewound tail
  assign retire     = valid[head] && done[head] &&
                      !(mispred && resolve_tag == head);

  // live slots are contiguous from head, so "younger than T"
  // is simply "age from head >= age of T"
  always_comb begin
    logic [TAG_W-1:0] age_i;
    logic [TAG_W-1:0] age_t;
    squash = '0;
    age_t  = resolve_tag - head;
    for (int i = 0; i < NUM_CKPT; i++) begin
      age_i = TAG_W'(i) - head;
      squash[i] = mispred && valid[i] && (age_i >= age_t);
    end
  end

  always_comb begin
    valid_nx = valid;
    done_nx  = done;
    head_nx  = head;
    tail_nx  = tail;
    if (resolve_ok)
      done_nx[resolve_tag] = 1'b1;
    if (retire) begin
      valid_nx[head] = 1'b0;
      done_nx[head]  = 1'b0;
      head_nx        = head + 1'b1;
    end
    if (alloc) begin
      valid_nx[tail] = 1'b1;
      done_nx[tail]  = 1'b0;
      tail_nx        = tail + 1'b1;
    end
    if (mispred) begin
      valid_nx = valid_nx & ~squash;
      done_nx  = done_nx & ~squash;
      tail_nx  = resolve_tag;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (mispred) state_nx = RECALL;
      RECALL:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      state <= state_nx;
      head  <= head_nx;
      tail  <= tail_nx;
      valid <= valid_nx;
      done  <= done_nx;
    end
  end

  // this cycle's free applied to every stored snapshot
  always_comb begin
    for (int i = 0; i < NUM_CKPT; i++) begin
      p_list[i] = s_list[i];
      p_back[i] = s_back[i];
      p_size[i] = s_size[i];
      if (if_freed) begin
        p_list[i] = put6(s_list[i], s_back[i], freed_reg);
        p_back[i] = s_back[i] + 6'd1;
        p_size[i] = s_size[i] + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (alloc && tail == TAG_W'(i)) begin
        s_list[i]  <= ckpt_list;
        s_front[i] <= ckpt_front_ptr;
        s_back[i]  <= ckpt_back_ptr;
        s_size[i]  <= ckpt_list_size;
      end else if (valid[i]) begin
        s_list[i]  <= p_list[i];
        s_back[i]  <= p_back[i];
        s_size[i]  <= p_size[i];
      end
    end
    if (mispred) begin
      r_list  <= p_list[resolve_tag];
      r_front <= s_front[resolve_tag];
      r_back  <= p_back[resolve_tag];
      r_size  <= p_size[resolve_tag];
    end
  end

  assign if_recall   = (state == RECALL);
  assign recall_busy = (state == RECALL);

  always_comb begin
    recalled_list      = '0;
    recalled_front_ptr = '0;
    recalled_back_ptr  = '0;
    recalled_list_size = '0;
    if (state == RECALL) begin
      recalled_list      = r_list;
      recalled_front_ptr = r_front;
      recalled_back_ptr  = r_back;
      recalled_list_size = r_size;
      if (if_freed) begin
        recalled_list      = put6(r_list, r_back, freed_reg);
        recalled_back_ptr  = r_back + 6'd1;
        recalled_list_size = r_size + 7'd1;
      end
    end
  end

`ifdef CKPT_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_mispredicts <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (mispred && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + 32'd1;
      if (ckpt_req && ckpt_full && perf_full_stalls != '1)
        perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_free_list_ckpt_ctrl.sv
// tb_free_list_ckpt_ctrl: randomized + directed scoreboard bench for
// free_list_ckpt_ctrl against a queue-based checkpoint model.
module tb_free_list_ckpt_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         ckpt_req;
  logic [383:0] ckpt_list;
  logic [5:0]   ckpt_front_ptr, ckpt_back_ptr;
  logic [6:0]   ckpt_list_size;
  logic [1:0]   ckpt_tag;
  logic         ckpt_full;
  logic         if_freed;
  logic [5:0]   freed_reg;
  logic         resolve_valid;
  logic [1:0]   resolve_tag;
  logic         resolve_mispredict;
  logic         if_recall;
  logic [383:0] recalled_list;
  logic [5:0]   recalled_front_ptr, recalled_back_ptr;
  logic [6:0]   recalled_list_size;
  logic         recall_busy;

  free_list_ckpt_ctrl #(.NUM_CKPT(4), .TAG_W(2)) dut (
    .clk(clk), .reset(reset),
    .ckpt_req(ckpt_req), .ckpt_list(ckpt_list),
    .ckpt_front_ptr(ckpt_front_ptr), .ckpt_back_ptr(ckpt_back_ptr),
    .ckpt_list_size(ckpt_list_size),
    .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
    .if_freed(if_freed), .freed_reg(freed_reg),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .if_recall(if_recall), .recalled_list(recalled_list),
    .recalled_front_ptr(recalled_front_ptr),
    .recalled_back_ptr(recalled_back_ptr),
    .recalled_list_size(recalled_list_size),
    .recall_busy(recall_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   tag;
    bit           done;
    logic [383:0] l;
    logic [5:0]   f;
    logic [5:0]   b;
    logic [6:0]   s;
  } ck_t;

  typedef struct {
    logic [1:0]   tag;
    logic         full;
    logic         rec;
    logic         busy;
    logic [383:0] rl;
    logic [5:0]   rf;
    logic [5:0]   rb;
    logic [6:0]   rs;
  } exp_t;

  ck_t  ck[$];
  ck_t  rec;
  bit   in_rec;
  int   next_tag;
  exp_t exq[$];

  int nvec = 0;
  int nmis = 0;

  function automatic ck_t patch(ck_t c, logic [5:0] r);
    c.l[int'(c.b)*6 +: 6] = r;
    c.b = c.b + 6'd1;
    c.s = c.s + 7'd1;
    return c;
  endfunction

  task automatic chk(string nm, logic [383:0] act, logic [383:0] ex);
    nvec++;
    if (act !== ex) begin
      nmis++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, ex);
    end
  endtask

  // one clock of stimulus: queue expected outputs, advance model
  task automatic step();
    exp_t e;
    ck_t  n;
    ck_t  r;
    int   ti;
    bit   full, rvm, mis, ok, alc, ret;
    full  = (ck.size() == 4);
    e.tag = 2'(next_tag);
    e.full = full;
    e.rec  = in_rec;
    e.busy = in_rec;
    e.rl = '0; e.rf = '0; e.rb = '0; e.rs = '0;
    if (in_rec) begin
      r = rec;
      if (if_freed) r = patch(r, freed_reg);
      e.rl = r.l; e.rf = r.f; e.rb = r.b; e.rs = r.s;
    end
    exq.push_back(e);
    if (!reset) begin
      ck.delete();
      next_tag = 0;
      in_rec = 0;
    end else begin
      ti = -1;
      foreach (ck[i]) if (ck[i].tag == resolve_tag) ti = i;
      rvm = resolve_valid && resolve_mispredict;
      mis = rvm && ti >= 0 && !in_rec;
      ok  = resolve_valid && !resolve_mispredict && ti >= 0;
      alc = ckpt_req && !full && !in_rec && !rvm;
      ret = ck.size() > 0 && ck[0].done && !(mis && ti == 0);
      if (if_freed)
        foreach (ck[i]) ck[i] = patch(ck[i], freed_reg);
      if (ok) ck[ti].done = 1;
      if (mis) begin
        rec = ck[ti];
        while (ck.size() > ti) void'(ck.pop_back());
        next_tag = int'(resolve_tag);
      end
      if (ret) void'(ck.pop_front());
      if (alc) begin
        n.tag = 2'(next_tag);
        n.done = 0;
        n.l = ckpt_list; n.f = ckpt_front_ptr;
        n.b = ckpt_back_ptr; n.s = ckpt_list_size;
        ck.push_back(n);
        next_tag = (next_tag + 1) % 4;
      end
      in_rec = mis;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ckpt_req = 0; if_freed = 0; resolve_valid = 0;
    resolve_mispredict = 0; resolve_tag = 0; freed_reg = 0;
  endtask

  task automatic rnd_snap();
    for (int k = 0; k < 12; k++) ckpt_list[k*32 +: 32] = $urandom;
    ckpt_front_ptr = 6'($urandom);
    ckpt_back_ptr  = 6'($urandom);
    ckpt_list_size = 7'($urandom);
  endtask

  task automatic req();
    quiet(); rnd_snap(); ckpt_req = 1; step();
  endtask

  task automatic res(logic [1:0] t, bit m);
    quiet(); resolve_valid = 1; resolve_tag = t;
    resolve_mispredict = m; step();
  endtask

  task automatic do_reset();
    quiet(); reset = 0; step(); reset = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("ckpt_tag", 384'(ckpt_tag), 384'(e.tag));
        chk("ckpt_full", 384'(ckpt_full), 384'(e.full));
        chk("if_recall", 384'(if_recall), 384'(e.rec));
        chk("recall_busy", 384'(recall_busy), 384'(e.busy));
        chk("recalled_list", recalled_list, e.rl);
        chk("recalled_front", 384'(recalled_front_ptr), 384'(e.rf));
        chk("recalled_back", 384'(recalled_back_ptr), 384'(e.rb));
        chk("recalled_size", 384'(recalled_list_size), 384'(e.rs));
      end
    end
  end

  initial begin : driver
    quiet();
    rnd_snap();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    ck.delete(); next_tag = 0; in_rec = 0;
    reset = 1;

    // fill all four slots, fifth request dropped
    quiet(); step();
    repeat (4) req();
    req();
    quiet(); step();

    // free patching into a recalled snapshot
    do_reset();
    quiet(); rnd_snap(); ckpt_req = 1;
    ckpt_back_ptr = 6'd10; ckpt_list_size = 7'd20; step();
    quiet(); if_freed = 1; freed_reg = 6'd45; step();
    step();
    res(2'd0, 1);
    quiet(); step();
    quiet(); step();

    // mispredict in the middle squashes younger slots
    do_reset();
    repeat (3) req();
    res(2'd1, 1);
    quiet(); step();
    req();
    repeat (3) req();

    // in-order retirement
    do_reset();
    repeat (2) req();
    res(2'd1, 0);
    res(2'd0, 0);
    quiet(); step();
    quiet(); step();
    repeat (4) req();

    // mispredict beats req; req during recall ignored
    do_reset();
    req();
    quiet(); rnd_snap(); ckpt_req = 1;
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 0;
    step();
    req();
    quiet(); step();
    req();

    // reset during the recall cycle aborts it
    do_reset();
    req(); req();
    res(2'd0, 1);
    quiet(); reset = 0; step();
    reset = 1; quiet(); step();
    repeat (4) req();

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      quiet(); rnd_snap();
      ckpt_req = ($urandom_range(0, 99) < 50);
      if_freed = ($urandom_range(0, 99) < 40);
      freed_reg = 6'($urandom);
      resolve_valid = ($urandom_range(0, 99) < 35);
      resolve_mispredict = ($urandom_range(0, 99) < 25);
      resolve_tag = 2'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      step();
      reset = 1;
    end

    quiet();
    repeat (3) @(negedge clk);
    if (exq.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending expected 0", exq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
